key_display_sched: RTL and testbench

Consumes the keypad scanner's key strobe together with its latched row and column. Decodes the pressed key to a hex digit and keeps a two-entry key history (newest, previous). Time-multiplexes one shared seven-segment decoder between two digits using a show/blank schedule, which prevents ghosting. Sits between the keypad input FSM and the sevenseg decoder plus the dual-digit anode drivers.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/key_decoder.sv | 25 ++
 rtl/key_display_sched.sv | 92 +++++++++
 tb/tb_key_display_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad display path: schedule states,
// key map and default slot timing.
package keypad_pkg;

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} disp_state_t;

  // Indexed by {row index, column index}
  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  localparam int SHOW_CYCLES_DEF  = 24000;
  localparam int BLANK_CYCLES_DEF = 480;
  localparam int CNT_W_DEF        = 24;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/key_decoder.sv
// Combinational keypad decode: one-hot row and column to a hex key code.
module key_decoder
  import keypad_pkg::*;
(
  input  logic [3:0] row_pwr,
  input  logic [3:0] cols,
  output logic [3:0] code,
  output logic       valid
);

  logic [1:0] row_idx;
  logic [1:0] col_idx;

  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_pwr[i]) row_idx = 2'(i);
      if (cols[i])    col_idx = 2'(i);
    end
    valid = is_onehot4(row_pwr) && is_onehot4(cols);
    code  = KEY_MAP[{row_idx, col_idx}];
  end

endmodule

// File: rtl/key_display_sched.sv
// Two-key history with a show/blank time-multiplexed schedule driving one
// shared seven-segment decoder and two active-low anodes.
module key_display_sched
  import keypad_pkg::*;
#(
  parameter int SHOW_CYCLES  = SHOW_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_key,
  input  logic [3:0] row_pwr,
  input  logic [3:0] cols,
  output logic [3:0] seg_val,
  output logic [1:0] anode,
  output logic [1:0] key_count
);

  localparam bit             HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  logic [3:0]       code;
  logic             code_vld;
  logic [3:0]       dig_new, dig_old;
  logic             val_new, val_old;
  disp_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;

  key_decoder u_key_decoder (
    .row_pwr (row_pwr),
    .cols    (cols),
    .code    (code),
    .valid   (code_vld)
  );

  // Key history: a ghosted or empty scan never reaches the registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_new   <= 4'd0;
      dig_old   <= 4'd0;
      val_new   <= 1'b0;
      val_old   <= 1'b0;
      key_count <= 2'd0;
    end else if (new_key && code_vld) begin
      dig_old <= dig_new;
      val_old <= val_new;
      dig_new <= code;
      val_new <= 1'b1;
      if (key_count != 2'd2) key_count <= key_count + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SHOW0:   if (cnt == SHOW_LAST)  state_nxt = HAS_BLANK ? BLANK0 : SHOW1;
      BLANK0:  if (cnt == BLANK_LAST) state_nxt = SHOW1;
      SHOW1:   if (cnt == SHOW_LAST)  state_nxt = HAS_BLANK ? BLANK1 : SHOW0;
      BLANK1:  if (cnt == BLANK_LAST) state_nxt = SHOW0;
      default: state_nxt = SHOW0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
    end
  end

  // Blank slots keep the last shown digit on seg_val so the decoder input
  // does not toggle while both anodes are off.
  always_comb begin
    anode   = 2'b11;
    seg_val = dig_new;
    case (state)
      SHOW0:  anode = val_new ? 2'b10 : 2'b11;
      SHOW1: begin
        anode   = val_old ? 2'b01 : 2'b11;
        seg_val = dig_old;
      end
      BLANK1: seg_val = dig_old;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_key_display_sched.sv
// Scoreboard bench: a phase-based reference model pushes expected outputs per
// cycle, tasks pop and compare after each edge.
module tb_key_display_sched;

  localparam int S  = 4;
  localparam int B  = 2;
  localparam int PA = 2 * S + 2 * B;
  localparam int PB = 2 * S;

  localparam logic [3:0] KEYS [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       new_key = 1'b0;
  logic [3:0] row_pwr = 4'd0;
  logic [3:0] cols = 4'd0;
  logic [3:0] a_seg, b_seg;
  logic [1:0] a_an, b_an, a_kc, b_kc;

  typedef struct {
    logic [1:0] an_a;
    logic [3:0] sv_a;
    logic [1:0] an_b;
    logic [3:0] sv_b;
    logic [1:0] kc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   fails = 0;

  int         ph_a, ph_b;
  logic [3:0] m_new, m_old;
  logic       m_vn, m_vo;
  logic [1:0] m_kc;

  always #5 clk = ~clk;

  key_display_sched #(.SHOW_CYCLES(S), .BLANK_CYCLES(B), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .new_key(new_key), .row_pwr(row_pwr), .cols(cols),
    .seg_val(a_seg), .anode(a_an), .key_count(a_kc)
  );

  key_display_sched #(.SHOW_CYCLES(S), .BLANK_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .new_key(new_key), .row_pwr(row_pwr), .cols(cols),
    .seg_val(b_seg), .anode(b_an), .key_count(b_kc)
  );

  always @(negedge clk) begin
    assert (a_an != 2'b00 && b_an != 2'b00)
    else begin
      fails++;
      $display("FAIL both_anodes_low t=%0t a=%b b=%b required_not=00", $time, a_an, b_an);
    end
  end

  function automatic int idx1h(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // Expected anode/seg for a given phase within the slot period
  function automatic void exp_disp(input int ph, input int blank,
                                   output logic [1:0] an, output logic [3:0] sv);
    if (ph < S) begin
      an = m_vn ? 2'b10 : 2'b11; sv = m_new;
    end else if (ph < S + blank) begin
      an = 2'b11; sv = m_new;
    end else if (ph < 2 * S + blank) begin
      an = m_vo ? 2'b01 : 2'b11; sv = m_old;
    end else begin
      an = 2'b11; sv = m_old;
    end
  endfunction

  task automatic tick(input logic nk, input logic [3:0] r, input logic [3:0] c, input logic rs);
    exp_t x;
    int ri, ci;
    reset = rs; new_key = nk; row_pwr = r; cols = c;
    if (rs) begin
      ph_a = 0; ph_b = 0;
      m_new = 4'd0; m_old = 4'd0; m_vn = 1'b0; m_vo = 1'b0; m_kc = 2'd0;
    end else begin
      ph_a = (ph_a + 1) % PA;
      ph_b = (ph_b + 1) % PB;
      ri = idx1h(r);
      ci = idx1h(c);
      if (nk && ri >= 0 && ci >= 0) begin
        m_old = m_new; m_vo = m_vn;
        m_new = KEYS[ri][ci]; m_vn = 1'b1;
        if (m_kc < 2) m_kc = m_kc + 2'd1;
      end
    end
    exp_disp(ph_a, B, x.an_a, x.sv_a);
    exp_disp(ph_b, 0, x.an_b, x.sv_b);
    x.kc = m_kc;
    q.push_back(x);
    @(posedge clk); #1;
    reset = 1'b0; new_key = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 4'd0, 4'd0, 1'b1);
      e = q.pop_front();
      vectors++;
      if ({a_an, a_seg, a_kc} !== {2'b11, 4'h0, 2'd0} || {a_an, a_seg, a_kc} !== {e.an_a, e.sv_a, e.kc}) begin
        fails++;
        $display("FAIL reset: anode=%b seg=%h count=%0d required anode=11 seg=0 count=0", a_an, a_seg, a_kc);
      end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 2 * PA; i++) begin
      tick(1'b0, 4'd0, 4'd0, 1'b0);
      e = q.pop_front();
      vectors++;
      if (a_an !== 2'b11 || {a_an, a_seg, a_kc} !== {e.an_a, e.sv_a, e.kc}) begin
        fails++;
        $display("FAIL idle[%0d]: anode=%b seg=%h count=%0d required anode=%b seg=%h count=%0d",
                 i, a_an, a_seg, a_kc, e.an_a, e.sv_a, e.kc);
      end
    end
  endtask

  task automatic test_keys();
    logic [3:0] kr [3] = '{4'b0001, 4'b1000, 4'b0010};
    logic [3:0] kc [3] = '{4'b0100, 4'b0010, 4'b0001};
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, kr[k], kc[k], 1'b0);
      for (int i = 0; i <= PA; i++) begin
        e = q.pop_front();
        vectors++;
        if ({a_an, a_seg, a_kc} !== {e.an_a, e.sv_a, e.kc}) begin
          fails++;
          $display("FAIL key%0d[%0d]: anode=%b seg=%h count=%0d required anode=%b seg=%h count=%0d",
                   k, i, a_an, a_seg, a_kc, e.an_a, e.sv_a, e.kc);
        end
        if (i < PA) tick(1'b0, 4'd0, 4'd0, 1'b0);
      end
    end
  endtask

  task automatic test_invalid();
    logic [3:0] ir [3] = '{4'b0001, 4'b0000, 4'b0100};
    logic [3:0] ic [3] = '{4'b0110, 4'b0100, 4'b0010};
    logic       nk [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < PA; i++) begin
        tick(i == 0 ? nk[k] : 1'b0, ir[k], ic[k], 1'b0);
        e = q.pop_front();
        vectors++;
        if ({a_an, a_seg, a_kc} !== {e.an_a, e.sv_a, e.kc}) begin
          fails++;
          $display("FAIL invalid%0d[%0d]: anode=%b seg=%h count=%0d required anode=%b seg=%h count=%0d",
                   k, i, a_an, a_seg, a_kc, e.an_a, e.sv_a, e.kc);
        end
      end
    end
  endtask

  task automatic test_edge_and_reset();
    for (int i = 0; i < 2 * PA + 20; i++) begin
      if (i == PA + 2) begin
        tick(1'b1, 4'b0100, 4'b1000, 1'b0);
      end else if (i == PA + 4) begin
        while (ph_a != S - 1) tick(1'b0, 4'd0, 4'd0, 1'b0);
        void'(q.pop_front());
        q.delete();
        tick(1'b1, 4'b0100, 4'b1000, 1'b0);
      end else if (i == PA + 12) begin
        q.delete();
        while (ph_a != S + B + 1) tick(1'b0, 4'd0, 4'd0, 1'b0);
        q.delete();
        tick(1'b1, 4'b0001, 4'b0001, 1'b1);
      end else begin
        tick(1'b0, 4'd0, 4'd0, 1'b0);
      end
      e = q.pop_front();
      vectors++;
      if ({a_an, a_seg, a_kc} !== {e.an_a, e.sv_a, e.kc}) begin
        fails++;
        $display("FAIL edge_rst[%0d]: anode=%b seg=%h count=%0d required anode=%b seg=%h count=%0d",
                 i, a_an, a_seg, a_kc, e.an_a, e.sv_a, e.kc);
      end
    end
  endtask

  task automatic test_no_blank();
    tick(1'b0, 4'd0, 4'd0, 1'b1);
    void'(q.pop_front());
    for (int i = 0; i < 3 * PB; i++) begin
      if (i == 1)      tick(1'b1, 4'b0010, 4'b0010, 1'b0);
      else if (i == 6) tick(1'b1, 4'b1000, 4'b1000, 1'b0);
      else             tick(1'b0, 4'd0, 4'd0, 1'b0);
      e = q.pop_front();
      vectors++;
      if ({b_an, b_seg, b_kc} !== {e.an_b, e.sv_b, e.kc}) begin
        fails++;
        $display("FAIL no_blank[%0d]: anode=%b seg=%h count=%0d required anode=%b seg=%h count=%0d",
                 i, b_an, b_seg, b_kc, e.an_b, e.sv_b, e.kc);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_idle();
    test_keys();
    test_invalid();
    test_edge_and_reset();
    test_no_blank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
